// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB receive control path
package usb_rx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CHK_SYNC,
    ST_PID,
    ST_CHK_PID,
    ST_TOKEN,
    ST_DATA,
    ST_LOAD,
    ST_WAIT,
    ST_EOP,
    ST_ERROR,
    ST_EIDLE,
    ST_READY
  } rx_state_t;

  localparam logic [2:0] PKT_NONE  = 3'd0;
  localparam logic [2:0] PKT_IN    = 3'd1;
  localparam logic [2:0] PKT_OUT   = 3'd2;
  localparam logic [2:0] PKT_DATA0 = 3'd3;
  localparam logic [2:0] PKT_DATA1 = 3'd4;
  localparam logic [2:0] PKT_ACK   = 3'd5;
  localparam logic [2:0] PKT_NAK   = 3'd6;
  localparam logic [2:0] PKT_STALL = 3'd7;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_SYNC     = 3'd1;
  localparam logic [2:0] ERR_PID      = 3'd2;
  localparam logic [2:0] ERR_EARLY    = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW = 3'd4;
  localparam logic [2:0] ERR_FULL     = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd6;

  localparam logic [7:0] PID_IN    = 8'h96;
  localparam logic [7:0] PID_OUT   = 8'h87;
  localparam logic [7:0] PID_ACK   = 8'h4B;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h78;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'hD2;

endpackage

// File: rtl/usb_pid_decode.sv
// rtl/usb_pid_decode.sv - combinational PID check: complement test plus class lookup
module usb_pid_decode
  import usb_rx_pkg::*;
(
  input  logic [7:0] pid_byte,
  output logic       pid_valid,
  output logic [2:0] pid_class
);

  always_comb begin
    pid_class = PKT_NONE;
    case (pid_byte)
      PID_IN:    pid_class = PKT_IN;
      PID_OUT:   pid_class = PKT_OUT;
      PID_DATA0: pid_class = PKT_DATA0;
      PID_DATA1: pid_class = PKT_DATA1;
      PID_ACK:   pid_class = PKT_ACK;
      PID_NAK:   pid_class = PKT_NAK;
      PID_STALL: pid_class = PKT_STALL;
      default:   pid_class = PKT_NONE;
    endcase
    pid_valid = (pid_byte[7:4] == ~pid_byte[3:0]) && (pid_class != PKT_NONE);
  end

endmodule

// File: rtl/usb_rx_ctrl_p.sv
// rtl/usb_rx_ctrl_p.sv - USB endpoint receive control FSM; optional watchdog via RX_TIMEOUT_EN
module usb_rx_ctrl_p
  import usb_rx_pkg::*;
#(
  parameter int         MAX_DATA_BYTES = 64,
  parameter logic [7:0] SYNC_BYTE      = 8'h80,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         CNT_W          = $clog2(MAX_DATA_BYTES + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             edge_sig,
  input  logic             byte_finish,
  input  logic             eop,
  input  logic             packet_done,
  input  logic [7:0]       rx_shift_register,
  input  logic             rx_buf_full,
  output logic             flush,
  output logic             rx_transfer_active,
  output logic             rx_data_ready,
  output logic             rx_error,
  output logic             store_rx_packet_data,
  output logic [2:0]       rx_packet,
  output logic [CNT_W-1:0] rx_byte_count,
  output logic [2:0]       rx_err_code
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_BYTES);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  rx_state_t  state, state_next;
  logic [2:0] err_set;
  logic       pid_valid;
  logic [2:0] pid_class;
  logic       store_q;
  logic       timeout;
  logic       restart;

  usb_pid_decode u_pid_decode (
    .pid_byte  (rx_shift_register),
    .pid_valid (pid_valid),
    .pid_class (pid_class)
  );

`ifdef RX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt <= '0;
    end else if (byte_finish || (state_next == ST_SYNC && state != ST_SYNC)) begin
      wd_cnt <= '0;
    end else if ((state == ST_SYNC || state == ST_PID || state == ST_DATA) &&
                 wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout = (wd_cnt == WD_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_set    = ERR_NONE;
    case (state)
      ST_IDLE, ST_EIDLE, ST_READY: if (edge_sig) state_next = ST_SYNC;
      ST_SYNC: begin
        if (byte_finish)  state_next = ST_CHK_SYNC;
        else if (eop)     begin state_next = ST_ERROR; err_set = ERR_EARLY;   end
        else if (timeout) begin state_next = ST_ERROR; err_set = ERR_TIMEOUT; end
      end
      ST_CHK_SYNC: begin
        if (rx_shift_register == SYNC_BYTE) state_next = ST_PID;
        else begin state_next = ST_ERROR; err_set = ERR_SYNC; end
      end
      ST_PID: begin
        if (byte_finish)  state_next = ST_CHK_PID;
        else if (eop)     begin state_next = ST_ERROR; err_set = ERR_EARLY;   end
        else if (timeout) begin state_next = ST_ERROR; err_set = ERR_TIMEOUT; end
      end
      ST_CHK_PID: begin
        if (!pid_valid) begin
          state_next = ST_ERROR;
          err_set    = ERR_PID;
        end else if (pid_class == PKT_DATA0 || pid_class == PKT_DATA1) begin
          state_next = ST_DATA;
        end else begin
          state_next = ST_TOKEN;
        end
      end
      ST_TOKEN: if (packet_done && eop) state_next = ST_EOP;
      ST_DATA: begin
        if (byte_finish) begin
          state_next = ST_LOAD;
        end else if (eop) begin
          if (rx_byte_count == '0) begin
            state_next = ST_ERROR;
            err_set    = ERR_EARLY;
          end else begin
            state_next = ST_EOP;
          end
        end else if (timeout) begin
          state_next = ST_ERROR;
          err_set    = ERR_TIMEOUT;
        end
      end
      ST_LOAD: begin
        if (rx_buf_full)                  begin state_next = ST_ERROR; err_set = ERR_FULL;     end
        else if (rx_byte_count == MAX_CNT) begin state_next = ST_ERROR; err_set = ERR_OVERFLOW; end
        else                              state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (packet_done) state_next = eop ? ST_EOP : ST_DATA;
      end
      ST_EOP:   state_next = ST_READY;
      ST_ERROR: if (eop && packet_done) state_next = ST_EIDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    flush                = (state == ST_SYNC);
    rx_data_ready        = (state == ST_READY);
    rx_error             = (state == ST_ERROR) || (state == ST_EIDLE);
    rx_transfer_active   = !((state == ST_IDLE) || (state == ST_EIDLE) || (state == ST_READY));
    store_rx_packet_data = store_q;
  end

  // A new packet edge from any resting state wipes the previous packet's report.
  assign restart = edge_sig && (state == ST_IDLE || state == ST_EIDLE || state == ST_READY);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      store_q       <= 1'b0;
      rx_packet     <= PKT_NONE;
      rx_byte_count <= '0;
      rx_err_code   <= ERR_NONE;
    end else begin
      store_q <= (state == ST_LOAD) && (state_next == ST_WAIT);
      if (restart) begin
        rx_packet     <= PKT_NONE;
        rx_byte_count <= '0;
        rx_err_code   <= ERR_NONE;
      end else begin
        if (state == ST_CHK_PID && pid_valid)
          rx_packet <= pid_class;
        if (state == ST_LOAD && state_next == ST_WAIT && rx_byte_count != MAX_CNT)
          rx_byte_count <= rx_byte_count + CNT_W'(1);
        if (state_next == ST_ERROR && state != ST_ERROR)
          rx_err_code <= err_set;
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl_p.sv
// tb/tb_usb_rx_ctrl_p.sv - directed self-checking bench for usb_rx_ctrl_p
module tb_usb_rx_ctrl_p;

  localparam int MAXB  = 4;
  localparam int CNT_W = $clog2(MAXB + 1);

  logic             clk = 1'b0;
  logic             n_rst;
  logic             edge_sig, byte_finish, eop, packet_done, rx_buf_full;
  logic [7:0]       rx_shift_register;
  logic             flush, rx_transfer_active, rx_data_ready, rx_error, store_rx_packet_data;
  logic [2:0]       rx_packet, rx_err_code;
  logic [CNT_W-1:0] rx_byte_count;

  int checks = 0;
  int errors = 0;
  int n_store = 0;
  int base;

  usb_rx_ctrl_p #(
    .MAX_DATA_BYTES (MAXB),
    .SYNC_BYTE      (8'h80),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .edge_sig             (edge_sig),
    .byte_finish          (byte_finish),
    .eop                  (eop),
    .packet_done          (packet_done),
    .rx_shift_register    (rx_shift_register),
    .rx_buf_full          (rx_buf_full),
    .flush                (flush),
    .rx_transfer_active   (rx_transfer_active),
    .rx_data_ready        (rx_data_ready),
    .rx_error             (rx_error),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet            (rx_packet),
    .rx_byte_count        (rx_byte_count),
    .rx_err_code          (rx_err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (store_rx_packet_data === 1'b1) n_store++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pkt();
    edge_sig = 1'b1; tick(); edge_sig = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_shift_register = b; byte_finish = 1'b1; tick();
    byte_finish = 1'b0; tick();
  endtask

  task automatic data_byte(input logic [7:0] b, input logic last);
    rx_shift_register = b; byte_finish = 1'b1; tick();
    byte_finish = 1'b0; tick();
    packet_done = 1'b1; eop = last; tick();
    packet_done = 1'b0; eop = 1'b0;
    if (last) tick();
  endtask

  task automatic finish_err();
    packet_done = 1'b1; eop = 1'b1; tick();
    packet_done = 1'b0; eop = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; edge_sig = 1'b0; byte_finish = 1'b0; eop = 1'b0;
    packet_done = 1'b0; rx_buf_full = 1'b0; rx_shift_register = 8'h00;
    tick(); tick();
    chk("rst_outputs", {flush, rx_transfer_active, rx_data_ready, rx_error, store_rx_packet_data}, 0);
    chk("rst_regs", {rx_packet, 5'(rx_byte_count), rx_err_code}, 0);
    n_rst = 1'b1; tick();

    // DATA0 with three payload bytes
    base = n_store;
    start_pkt();
    chk("sync_flush", flush, 1);
    chk("sync_active", rx_transfer_active, 1);
    send_byte(8'h80);
    send_byte(8'hC3);
    data_byte(8'h11, 1'b0);
    data_byte(8'h22, 1'b0);
    data_byte(8'h33, 1'b1);
    chk("d0_stores", n_store - base, 3);
    chk("d0_count", rx_byte_count, 3);
    chk("d0_class", rx_packet, 3);
    chk("d0_ready", rx_data_ready, 1);
    chk("d0_err", rx_err_code, 0);
    chk("d0_idle", rx_transfer_active, 0);

    // ACK handshake
    base = n_store;
    start_pkt();
    chk("restart_clear", {rx_packet, 5'(rx_byte_count)}, 0);
    send_byte(8'h80);
    send_byte(8'h4B);
    packet_done = 1'b1; eop = 1'b1; tick();
    packet_done = 1'b0; eop = 1'b0; tick();
    chk("ack_class", rx_packet, 5);
    chk("ack_ready", rx_data_ready, 1);
    chk("ack_stores", n_store - base, 0);

    // bad SYNC, then EIDLE, then recovery on edge
    start_pkt();
    send_byte(8'h81);
    chk("bsync_err", rx_error, 1);
    chk("bsync_code", rx_err_code, 1);
    edge_sig = 1'b1; tick(); edge_sig = 1'b0;
    chk("bsync_edge_ignored", {rx_error, flush}, 2'b10);
    finish_err();
    chk("eidle_err", rx_error, 1);
    chk("eidle_code", rx_err_code, 1);
    chk("eidle_inactive", rx_transfer_active, 0);
    start_pkt();
    chk("recover_code", rx_err_code, 0);
    chk("recover_flush", flush, 1);

    // PID complement failure
    send_byte(8'h80);
    send_byte(8'hC2);
    chk("bpid_code", rx_err_code, 2);
    chk("bpid_class", rx_packet, 0);
    finish_err();

    // DATA1 overflow at MAX bytes
    base = n_store;
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hD2);
    for (int i = 0; i < 4; i++) data_byte(8'(i), 1'b0);
    rx_shift_register = 8'hEE; byte_finish = 1'b1; tick();
    byte_finish = 1'b0; tick();
    chk("ovf_code", rx_err_code, 4);
    chk("ovf_stores", n_store - base, 4);
    chk("ovf_count", rx_byte_count, 4);
    chk("ovf_class", rx_packet, 4);
    finish_err();

    // FIFO full on the second byte
    base = n_store;
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hC3);
    data_byte(8'hA1, 1'b0);
    rx_buf_full = 1'b1;
    rx_shift_register = 8'hA2; byte_finish = 1'b1; tick();
    byte_finish = 1'b0; tick();
    rx_buf_full = 1'b0;
    chk("full_code", rx_err_code, 5);
    chk("full_stores", n_store - base, 1);
    chk("full_count", rx_byte_count, 1);
    finish_err();

    // early EOP in SYNC and in DATA before any byte
    start_pkt();
    eop = 1'b1; tick(); eop = 1'b0;
    chk("early_sync_code", rx_err_code, 3);
    finish_err();
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hC3);
    eop = 1'b1; tick(); eop = 1'b0;
    chk("early_data_code", rx_err_code, 3);
    chk("early_data_err", rx_error, 1);
    finish_err();

    // reset while in LOAD: no strobe may follow
    base = n_store;
    start_pkt();
    send_byte(8'h80);
    send_byte(8'hC3);
    rx_shift_register = 8'h55; byte_finish = 1'b1; tick();
    byte_finish = 1'b0;
    n_rst = 1'b0; #1;
    chk("midrst_outputs", {flush, rx_transfer_active, rx_data_ready, rx_error, store_rx_packet_data}, 0);
    tick(); tick();
    chk("midrst_stores", n_store - base, 0);
    chk("midrst_regs", {rx_packet, 5'(rx_byte_count), rx_err_code}, 0);
    n_rst = 1'b1; tick();

    // stall after SYNC while waiting for the PID
    start_pkt();
    send_byte(8'h80);
    repeat (20) tick();
`ifdef RX_TIMEOUT_EN
    chk("stall_code", rx_err_code, 6);
    chk("stall_err", rx_error, 1);
`else
    chk("stall_code", rx_err_code, 0);
    chk("stall_active", {rx_transfer_active, rx_error}, 2'b10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
